// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - store buffer between memory-stage control and dataMemory (optional STORE_FWD_EN: forward exact-hit loads)
module mem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        empty,
    output logic [63:0] address,
    output logic [63:0] writeData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [63:0] readData
);

    localparam int PW = $clog2(DEPTH);

    logic [63:0]   r_addr [DEPTH];
    logic [63:0]   r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          r_rsp_valid;
    logic [63:0]   r_rsp_data;

    logic          w_full;
    logic          w_any_hit;
    logic          w_any_partial;
    logic [63:0]   w_fwd_data;
    logic [PW-1:0] w_idx;
    logic [63:0]   w_diff_f;
    logic [63:0]   w_diff_b;
    logic          w_stall;
    logic          w_fwd;
    logic          w_load_acc;
    logic          w_store_acc;

    assign w_full = (r_count == (PW+1)'(DEPTH));
    assign empty  = (r_count == '0);

    // Scan live entries oldest to youngest; the last exact match seen is the youngest one.
    always_comb begin
        w_any_hit     = 1'b0;
        w_any_partial = 1'b0;
        w_fwd_data    = '0;
        w_idx         = '0;
        w_diff_f      = '0;
        w_diff_b      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW+1)'(k) < r_count) begin
                w_idx    = r_head + PW'(k);
                w_diff_f = req_addr - r_addr[w_idx];
                w_diff_b = r_addr[w_idx] - req_addr;
                if (w_diff_f == 64'd0) begin
                    w_any_hit  = 1'b1;
                    w_fwd_data = r_data[w_idx];
                end else if ((w_diff_f <= 64'd7) || (w_diff_b <= 64'd7)) begin
                    w_any_partial = 1'b1;
                end
            end
        end
    end

    // Decide whether a load must wait for queued stores or can be served now.
    always_comb begin
`ifdef STORE_FWD_EN
        w_stall = w_any_partial;
        w_fwd   = w_any_hit;
`else
        w_stall = w_any_hit | w_any_partial;
        w_fwd   = 1'b0;
`endif
    end

    // Handshake and memory-port arbitration: a memory load wins over a drain.
    always_comb begin
        req_ready = 1'b0;
        if (!reset) begin
            if (req_valid && !req_write) req_ready = !w_stall;
            else                         req_ready = !w_full;
        end
        w_load_acc  = req_valid & !req_write & req_ready;
        w_store_acc = req_valid &  req_write & req_ready;
        memRead     = w_load_acc & !w_fwd;
        memWrite    = !reset & !memRead & !empty;
        address     = '0;
        writeData   = '0;
        if (memRead) begin
            address = req_addr;
        end else if (memWrite) begin
            address   = r_addr[r_head];
            writeData = r_data[r_head];
        end
    end

    // Pointer, occupancy and load-response state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (w_store_acc) r_tail <= r_tail + 1'b1;
            if (memWrite)    r_head <= r_head + 1'b1;
            r_count     <= r_count + (PW+1)'(w_store_acc) - (PW+1)'(memWrite);
            r_rsp_valid <= w_load_acc;
            if (w_load_acc) r_rsp_data <= w_fwd ? w_fwd_data : readData;
        end
    end

    // Entry storage needs no reset; only slots below the count are ever read.
    always_ff @(posedge clock) begin
        if (w_store_acc) begin
            r_addr[r_tail] <= req_addr;
            r_data[r_tail] <= req_wdata;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mem_store_buffer.sv
// tb/tb_mem_store_buffer.sv - randomized self-checking bench for mem_store_buffer against a queue/memory reference model
module tb_mem_store_buffer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        empty;
    logic [63:0] address;
    logic [63:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [63:0] readData = '0;

    mem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .empty(empty),
        .address(address), .writeData(writeData),
        .memWrite(memWrite), .memRead(memRead), .readData(readData)
    );

    always #5 clock = ~clock;

    typedef struct { logic [63:0] a; logic [63:0] d; } st_t;

    st_t         q[$];
    logic [7:0]  pmem [0:127];
    logic [7:0]  amem [0:127];
    int          nchk = 0;
    int          nfail = 0;
    bit          pend = 0;
    logic [63:0] pend_data = '0;
    bit          last_acc = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] rd(input bit arch, input logic [63:0] a);
        logic [63:0] r;
        logic [6:0]  idx;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            idx = a[6:0] + 7'(b);
            r[8*b +: 8] = arch ? amem[idx] : pmem[idx];
        end
        return r;
    endfunction

    task automatic wr(input bit arch, input logic [63:0] a, input logic [63:0] d);
        logic [6:0] idx;
        for (int b = 0; b < 8; b++) begin
            idx = a[6:0] + 7'(b);
            if (arch) amem[idx] = d[8*b +: 8];
            else      pmem[idx] = d[8*b +: 8];
        end
    endtask

    // 2 = exact hit, 1 = partial overlap, 0 = disjoint
    function automatic int ovl(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] f, b;
        f = x - y;
        b = y - x;
        if (f == 64'd0) return 2;
        if (f <= 64'd7 || b <= 64'd7) return 1;
        return 0;
    endfunction

    task automatic step(input bit rst, input bit v, input bit w,
                        input logic [63:0] a, input logic [63:0] d);
        bit hit, part, stall, fwd, e_ready, ld, st, e_rd, e_wr;
        logic [63:0] e_addr, e_wd, s_addr, s_wd;
        logic s_mw;
        @(negedge clock);
        reset = rst; req_valid = v; req_write = w; req_addr = a; req_wdata = d;
        #1 readData = rd(0, address);
        #1;
        hit = 0; part = 0;
        foreach (q[i]) begin
            if (ovl(a, q[i].a) == 2) hit = 1;
            if (ovl(a, q[i].a) == 1) part = 1;
        end
`ifdef STORE_FWD_EN
        stall = part; fwd = hit;
`else
        stall = hit | part; fwd = 0;
`endif
        if (rst)          e_ready = 0;
        else if (v && !w) e_ready = !stall;
        else              e_ready = (q.size() < DEPTH);
        ld   = v && !w && e_ready;
        st   = v &&  w && e_ready;
        e_rd = ld && !fwd;
        e_wr = !rst && !e_rd && (q.size() > 0);
        e_addr = e_rd ? a : (e_wr ? q[0].a : 64'd0);
        e_wd   = e_wr ? q[0].d : 64'd0;
        check("req_ready", {63'd0, req_ready}, {63'd0, e_ready});
        check("memRead",   {63'd0, memRead},   {63'd0, e_rd});
        check("memWrite",  {63'd0, memWrite},  {63'd0, e_wr});
        check("address",   address, e_addr);
        check("writeData", writeData, e_wd);
        check("empty",     {63'd0, empty}, {63'd0, q.size() == 0});
        check("rsp_valid", {63'd0, rsp_valid}, {63'd0, pend});
        if (pend) check("rsp_data", rsp_data, pend_data);
        s_mw = memWrite; s_addr = address; s_wd = writeData;
        @(posedge clock);
        if (s_mw === 1'b1) wr(0, s_addr, s_wd);
        if (e_wr) void'(q.pop_front());
        pend = ld;
        if (ld) pend_data = rd(1, a);
        if (st) begin
            q.push_back('{a: a, d: d});
            wr(1, a, d);
        end
        if (rst) begin
            q.delete();
            pend = 0;
            for (int i = 0; i < 128; i++) amem[i] = pmem[i];
        end
        last_acc = ld || st;
    endtask

    task automatic issue(input bit w, input logic [63:0] a, input logic [63:0] d);
        int n = 0;
        do begin
            step(0, 1, w, a, d);
            n++;
        end while (!last_acc && n < 20);
        check("issue_accepted", {63'd0, last_acc}, 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 64'd0, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit hv, hw;
        logic [63:0] ha, hd;
        for (int i = 0; i < 128; i++) begin
            pmem[i] = 8'($urandom);
            amem[i] = pmem[i];
        end
        repeat (2) @(posedge clock);
        step(1, 0, 0, 64'd0, 64'd0);

        // single store then load of the same word
        issue(1, 64'h08, 64'h1122334455667788);
        issue(0, 64'h08, 64'd0);
        step(0, 0, 0, 64'd0, 64'd0);
        check("plan1_rsp", rsp_data, 64'h1122334455667788);
        idle(2);

        // back-to-back stores including address reuse
        issue(1, 64'h00, 64'hA0); issue(1, 64'h08, 64'hA1); issue(1, 64'h10, 64'hA2);
        issue(1, 64'h18, 64'hA3); issue(1, 64'h00, 64'hA4);
        idle(3);

        // same-address stores, then load of that address
        issue(1, 64'h10, 64'hAA); issue(1, 64'h10, 64'hBB); issue(0, 64'h10, 64'd0);
        idle(2);

        // partial overlap, then load priority over a pending drain
        issue(1, 64'h08, 64'hDEADBEEFCAFEF00D); issue(0, 64'h0C, 64'd0);
        idle(1);
        issue(1, 64'h00, 64'h55); issue(0, 64'h18, 64'd0);
        idle(2);

        // reset while a store is queued: it must never reach memory
        ha = rd(0, 64'h20);
        issue(1, 64'h20, 64'hFFFF0000FFFF0000);
        step(1, 0, 0, 64'd0, 64'd0);
        idle(1);
        issue(0, 64'h20, 64'd0);
        step(0, 0, 0, 64'd0, 64'd0);
        check("plan6_discard", rsp_data, ha);

        hv = 0; hw = 0; ha = '0; hd = '0;
        for (int i = 0; i < 800; i++) begin
            if (!(hv && !last_acc && $urandom_range(0, 3) != 0)) begin
                hv = ($urandom_range(0, 3) != 0);
                hw = 1'($urandom_range(0, 1));
                ha = 64'($urandom_range(0, 14)) * 64'd4;
                hd = {$urandom, $urandom};
            end
            step($urandom_range(0, 49) == 0, hv, hw, ha, hd);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
